ro_icache: RTL

Direct-mapped, read-only instruction cache that sits between the processor fetch port and the prefetch controller's cache-side interface. It returns a 32-bit instruction in the same cycle on a hit. On a miss it stalls the processor and issues a 128-bit line refill request using a 28-bit block address. The cache never writes to memory.

---
 rtl/ro_icache.sv | 100 ++++++++++
 1 files changed

// File: rtl/ro_icache.sv
// Direct-mapped read-only instruction cache: same-cycle hit data, single-line refill on a miss.
// Define ICACHE_FWD_EN to forward the refill word to the processor in the cycle mem_ready arrives.
module ro_icache #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic [29:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ALLOC = 1'b1;

  logic [0:0]            state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [127:0]          data_mem [NUM_BLOCKS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [127:0]     req_line;
  logic [31:0]      hit_word;
  logic             hit;
  logic             fill;

  assign req_idx  = proc_addr[IDX_W+1:2];
  assign req_tag  = proc_addr[29:IDX_W+2];
  // The refill target comes from the registered block address, so it stays correct if the request drops.
  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[27:IDX_W];

  assign req_line = data_mem[req_idx];
  assign hit_word = req_line[{proc_addr[1:0], 5'b0} +: 32];
  assign hit      = proc_read && valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill     = (state == S_ALLOC) && mem_ready;

  // NOTE: every output gets a default before the branches, so no latch is inferred.
  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    if (proc_read) begin
      if (state == S_ALLOC) begin
`ifdef ICACHE_FWD_EN
        if (mem_ready) begin
          proc_rdata = mem_rdata[{proc_addr[1:0], 5'b0} +: 32];
        end else begin
          proc_stall = 1'b1;
        end
`else
        proc_stall = 1'b1;
`endif
      end else if (hit) begin
        proc_rdata = hit_word;
      end else begin
        proc_stall = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_read <= 1'b0;
      mem_addr <= '0;
      valid    <= '0;
    end else if (state == S_IDLE) begin
      if (proc_read && !hit) begin
        state    <= S_ALLOC;
        mem_read <= 1'b1;
        mem_addr <= proc_addr[29:2];
      end
    end else if (mem_ready) begin
      state           <= S_IDLE;
      mem_read        <= 1'b0;
      valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide whether a line may hit.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_rdata;
    end
  end

endmodule
